// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue sequencer: ALU op codes, sequencer states,
// instruction field positions and the R-type opf -> op_code mapping.
// Ports: none (package).
package definitions;

  typedef enum logic [1:0] {
    OP_OR  = 2'b00,
    OP_AND = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } op_code;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    READ = 2'b01,
    EXEC = 2'b10,
    WB   = 2'b11
  } issue_state_t;

  // R-type opf encodings (instr[14:13])
  localparam logic [1:0] OPF_OR  = 2'b00;
  localparam logic [1:0] OPF_AND = 2'b01;
  localparam logic [1:0] OPF_ADD = 2'b10;
  localparam logic [1:0] OPF_SUB = 2'b11;

  // Instruction field positions
  localparam int LI_BIT  = 15;
  localparam int OPF_LSB = 13;
  localparam int RD_LSB  = 11;
  localparam int RS_LSB  = 9;
  localparam int RT_LSB  = 7;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = 8;

  function automatic op_code opf_to_op(input logic [1:0] opf);
    op_code op;
    case (opf)
      OPF_OR:  op = OP_OR;
      OPF_AND: op = OP_AND;
      OPF_ADD: op = OP_ADD;
      default: op = OP_SUB;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_reg_file.sv
// Register file for the issue sequencer: 2**REG_AW x DATA_W, two async operand read
// ports plus an async debug read port, one synchronous write port, async active-low clear.
// Ports: clk, rst_n, i_we/i_waddr/i_wdata, i_raddr_a/o_rdata_a, i_raddr_b/o_rdata_b, i_dbg_addr/o_dbg_data.
module reg_file #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [REG_AW-1:0] i_raddr_a,
  output logic [DATA_W-1:0] o_rdata_a,
  input  logic [REG_AW-1:0] i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_b,
  input  logic [REG_AW-1:0] i_dbg_addr,
  output logic [DATA_W-1:0] o_dbg_data
);

  localparam int NREG = 2 ** REG_AW;

  logic [DATA_W-1:0] r_mem [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a  = r_mem[i_raddr_a];
  assign o_rdata_b  = r_mem[i_raddr_b];
  assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Instruction sequencer driving an external combinational ALU: accepts 16-bit instructions
// over valid/ready, reads operands, issues op/operands, captures result/zero, writes back.
// Ports: clk, rst_n, instr_valid_i/instr_ready_o/instr_i, op_o/rs_o/rt_o -> ALU,
// result_i/zero_i <- ALU, done_o, zero_flag_o, busy_o, dbg_addr_i/dbg_data_o.
module alu_issue_ctrl
  import definitions::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid_i,
  output logic              instr_ready_o,
  input  logic [15:0]       instr_i,
  output op_code            op_o,
  output logic [DATA_W-1:0] rs_o,
  output logic [DATA_W-1:0] rt_o,
  input  logic [DATA_W-1:0] result_i,
  input  logic              zero_i,
  output logic              done_o,
  output logic              zero_flag_o,
  output logic              busy_o,
  input  logic [REG_AW-1:0] dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o
);

  issue_state_t r_state, w_next;

  // Fields latched at acceptance
  logic              r_is_li;
  op_code            r_op;
  logic [REG_AW-1:0] r_rd, r_rs_a, r_rt_a;
  logic [IMM_W-1:0]  r_imm;

  // Issued operands and captured ALU outputs
  op_code            r_op_o;
  logic [DATA_W-1:0] r_rs_o, r_rt_o;
  logic [DATA_W-1:0] r_res;
  logic              r_zero;
  logic              r_zero_flag;

  logic              w_accept;
  logic [DATA_W-1:0] w_rdata_a, w_rdata_b;

  assign w_accept = (r_state == IDLE) && instr_valid_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (instr_valid_i) w_next = READ;
      READ:    w_next = EXEC;
      EXEC:    w_next = WB;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_li     <= 1'b0;
      r_op        <= OP_OR;
      r_rd        <= '0;
      r_rs_a      <= '0;
      r_rt_a      <= '0;
      r_imm       <= '0;
      r_op_o      <= OP_OR;
      r_rs_o      <= '0;
      r_rt_o      <= '0;
      r_res       <= '0;
      r_zero      <= 1'b0;
      r_zero_flag <= 1'b0;
    end else begin
      if (w_accept) begin
        r_is_li <= instr_i[LI_BIT];
        // LI rides the OR path with rt=0, so the ALU sees one uniform operation
        r_op    <= instr_i[LI_BIT] ? OP_OR : opf_to_op(instr_i[OPF_LSB +: 2]);
        r_rd    <= instr_i[RD_LSB +: REG_AW];
        r_rs_a  <= instr_i[RS_LSB +: REG_AW];
        r_rt_a  <= instr_i[RT_LSB +: REG_AW];
        r_imm   <= instr_i[IMM_LSB +: IMM_W];
      end
      // Operand registers only change in READ, so the ALU inputs stay stable in IDLE
      if (r_state == READ) begin
        r_op_o <= r_op;
        r_rs_o <= r_is_li ? {{(DATA_W-IMM_W){1'b0}}, r_imm} : w_rdata_a;
        r_rt_o <= r_is_li ? '0 : w_rdata_b;
      end
      if (r_state == EXEC) begin
        r_res  <= result_i;
        r_zero <= zero_i;
      end
      if (r_state == WB) begin
        r_zero_flag <= r_zero;
      end
    end
  end

  reg_file #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_reg_file (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_we       (r_state == WB),
    .i_waddr    (r_rd),
    .i_wdata    (r_res),
    .i_raddr_a  (r_rs_a),
    .o_rdata_a  (w_rdata_a),
    .i_raddr_b  (r_rt_a),
    .o_rdata_b  (w_rdata_b),
    .i_dbg_addr (dbg_addr_i),
    .o_dbg_data (dbg_data_o)
  );

  assign instr_ready_o = (r_state == IDLE);
  assign busy_o        = (r_state != IDLE);
  assign done_o        = (r_state == WB);
  assign op_o          = r_op_o;
  assign rs_o          = r_rs_o;
  assign rt_o          = r_rt_o;
  assign zero_flag_o   = r_zero_flag;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural combinational ALU attached.
module tb_alu_issue_ctrl;
  import definitions::*;

  localparam int DATA_W = 32;
  localparam int REG_AW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              instr_valid_i;
  logic              instr_ready_o;
  logic [15:0]       instr_i;
  op_code            op_o;
  logic [DATA_W-1:0] rs_o, rt_o;
  logic [DATA_W-1:0] result_i;
  logic              zero_i;
  logic              done_o, zero_flag_o, busy_o;
  logic [REG_AW-1:0] dbg_addr_i;
  logic [DATA_W-1:0] dbg_data_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_valid_i (instr_valid_i),
    .instr_ready_o (instr_ready_o),
    .instr_i       (instr_i),
    .op_o          (op_o),
    .rs_o          (rs_o),
    .rt_o          (rt_o),
    .result_i      (result_i),
    .zero_i        (zero_i),
    .done_o        (done_o),
    .zero_flag_o   (zero_flag_o),
    .busy_o        (busy_o),
    .dbg_addr_i    (dbg_addr_i),
    .dbg_data_o    (dbg_data_o)
  );

  // External ALU
  always_comb begin
    case (op_o)
      OP_OR:   result_i = rs_o | rt_o;
      OP_AND:  result_i = rs_o & rt_o;
      OP_ADD:  result_i = rs_o + rt_o;
      default: result_i = rs_o - rt_o;
    endcase
    zero_i = (result_i == '0);
  end

  function automatic logic [15:0] li(input int rd, input int imm);
    logic [15:0] w;
    w = 16'h8000;
    w[12:11] = rd[1:0];
    w[7:0]   = imm[7:0];
    return w;
  endfunction

  function automatic logic [15:0] rtype(input int opf, input int rd, input int rs, input int rt);
    logic [15:0] w;
    w = 16'h0000;
    w[14:13] = opf[1:0];
    w[12:11] = rd[1:0];
    w[10:9]  = rs[1:0];
    w[8:7]   = rt[1:0];
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input int addr, input logic [31:0] exp);
    dbg_addr_i = addr[REG_AW-1:0];
    #1;
    chk(tag, dbg_data_o, exp);
  endtask

  // Issue one instruction and check the handshake and done timing cycle by cycle
  task automatic issue(input string tag, input logic [15:0] w);
    @(posedge clk); #1;
    instr_i = w;
    instr_valid_i = 1'b1;
    #1 chk({tag, "_ready"}, {31'd0, instr_ready_o}, 32'd1);
    @(posedge clk); #1;
    instr_valid_i = 1'b0;
    chk({tag, "_done_read"}, {31'd0, done_o}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy_o}, 32'd1);
    @(posedge clk); #1;
    chk({tag, "_done_exec"}, {31'd0, done_o}, 32'd0);
    @(posedge clk); #1;
    chk({tag, "_done_wb"}, {31'd0, done_o}, 32'd1);
    @(posedge clk); #1;
    chk({tag, "_done_after"}, {31'd0, done_o}, 32'd0);
    chk({tag, "_ready_after"}, {31'd0, instr_ready_o}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b1;
    instr_valid_i = 1'b0;
    instr_i = 16'h0;
    dbg_addr_i = '0;

    // 1: reset pulse mid-cycle
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_zflag", {31'd0, zero_flag_o}, 32'd0);
    chk("rst_op", {30'd0, op_o}, {30'd0, OP_OR});
    chk("rst_rs", rs_o, 32'd0);
    chk("rst_rt", rt_o, 32'd0);
    for (int i = 0; i < 4; i++) rd_chk("rst_reg", i, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("rst_ready", {31'd0, instr_ready_o}, 32'd1);

    // 2: LI / ADD
    issue("li_r1", li(1, 8'h7F));
    issue("li_r2", li(2, 8'h05));
    issue("add_r3", rtype(2, 3, 1, 2));
    rd_chk("add_r3_val", 3, 32'h0000_0084);
    chk("add_zflag", {31'd0, zero_flag_o}, 32'd0);

    // 3: AND / OR
    issue("li_r1b", li(1, 8'hF0));
    issue("li_r2b", li(2, 8'h3C));
    issue("and_r0", rtype(1, 0, 1, 2));
    rd_chk("and_r0_val", 0, 32'h0000_0030);
    issue("or_r3", rtype(0, 3, 1, 2));
    rd_chk("or_r3_val", 3, 32'h0000_00FC);

    // 4: SUB with zero, then negative wrap
    issue("sub_r0", rtype(3, 0, 1, 1));
    rd_chk("sub_r0_val", 0, 32'h0);
    chk("sub_zflag1", {31'd0, zero_flag_o}, 32'd1);
    issue("li_r1c", li(1, 8'h7F));
    chk("li_clears_zflag", {31'd0, zero_flag_o}, 32'd0);
    issue("li_r2c", li(2, 8'h05));
    issue("sub_r3", rtype(3, 3, 2, 1));
    rd_chk("sub_r3_val", 3, 32'hFFFF_FF86);
    chk("sub_zflag0", {31'd0, zero_flag_o}, 32'd0);

    // 5: valid held 10 cycles with a new word each cycle; accepts land on i=0,4,8
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      if (i % 4 == 0) instr_i = li(i / 4 + 1, 8'h10 + i);
      else            instr_i = li(0, 8'hA0 + i);
      instr_valid_i = 1'b1;
      #1;
      chk("bp_ready", {31'd0, instr_ready_o}, {31'd0, (i % 4 == 0)});
      chk("bp_done", {31'd0, done_o}, {31'd0, (i % 4 == 3)});
      @(posedge clk); #1;
    end
    instr_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("bp_idle", {31'd0, instr_ready_o}, 32'd1);
    rd_chk("bp_r0", 0, 32'h0);
    rd_chk("bp_r1", 1, 32'h10);
    rd_chk("bp_r2", 2, 32'h14);
    rd_chk("bp_r3", 3, 32'h18);

    // 6: reset while ADD r3 is in EXEC
    @(posedge clk); #1;
    instr_i = rtype(2, 3, 1, 2);
    instr_valid_i = 1'b1;
    @(posedge clk); #1;
    instr_valid_i = 1'b0;
    @(posedge clk); #1;
    chk("mid_in_exec", {31'd0, busy_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_done", {31'd0, done_o}, 32'd0);
    chk("mid_busy", {31'd0, busy_o}, 32'd0);
    rd_chk("mid_r3", 3, 32'h0);
    rd_chk("mid_r1", 1, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("mid_ready", {31'd0, instr_ready_o}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("mid_no_done", {31'd0, done_o}, 32'd0);
    end
    rd_chk("mid_r3_after", 3, 32'h0);
    issue("li_r3_post", li(3, 8'h11));
    rd_chk("li_r3_post_val", 3, 32'h11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
